// File: rtl/mac_select_sequencer.sv
// Control stage ahead of the 32-lane select-accumulate MAC: streams each job's select words
// from select memory, waits for the MAC to drain, then returns the job's accumulator delta.
module mac_select_sequencer #(
   parameter int ACC_WIDTH   = 27,
   parameter int ADDR_W      = 10,
   parameter int LEN_W       = 7,
   parameter int MAC_LATENCY = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic [ADDR_W-1:0]    job_base_addr,
   input  logic [LEN_W-1:0]     job_len,
   output logic                 mem_rd_en,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [31:0]          mem_rdata,
   output logic [31:0]          mac_sel,
   input  logic [ACC_WIDTH-1:0] mac_out,
   input  logic                 mac_out_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [ACC_WIDTH-1:0] res_data,
   output logic                 busy
);

   localparam int                 DRAIN_W    = $clog2(MAC_LATENCY + 3);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LATENCY + 2);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RESULT} state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [LEN_W-1:0]     r_remaining;
   logic [ADDR_W-1:0]    r_rd_addr;
   logic [ACC_WIDTH-1:0] r_base_snap;
   logic [DRAIN_W-1:0]   r_drain_cnt;
   logic                 r_rd_pend;
   logic [31:0]          r_mac_sel;
   logic [ACC_WIDTH-1:0] r_res_data;
   logic                 w_accept;

   assign mem_addr = r_rd_addr;
   assign mac_sel  = r_mac_sel;
   assign res_data = r_res_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: every output of this block is given a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      job_ready    = 1'b0;
      mem_rd_en    = 1'b0;
      res_valid    = 1'b0;
      busy         = (r_state != IDLE);
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            job_ready = mac_out_ready;
            w_accept  = job_valid && mac_out_ready;
            if (w_accept) w_next_state = (job_len == '0) ? RESULT : FETCH;
         end
         FETCH: begin
            mem_rd_en = 1'b1;
            if (r_remaining == LEN_W'(1)) w_next_state = DRAIN;
         end
         DRAIN: begin
            if (r_drain_cnt == DRAIN_LAST) w_next_state = RESULT;
         end
         RESULT: begin
            res_valid = 1'b1;
            if (res_ready) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_remaining <= '0;
         r_rd_addr   <= '0;
         r_base_snap <= '0;
         r_drain_cnt <= '0;
         r_rd_pend   <= 1'b0;
         r_mac_sel   <= '0;
         r_res_data  <= '0;
      end else begin
         // Read data lands one cycle after the strobe; it is forwarded only in that cycle.
         r_rd_pend <= mem_rd_en;
         r_mac_sel <= r_rd_pend ? mem_rdata : 32'h0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_remaining <= job_len;
                  r_rd_addr   <= job_base_addr;
                  r_base_snap <= mac_out;
                  r_drain_cnt <= '0;
                  if (job_len == '0) r_res_data <= '0;
               end
            end
            FETCH: begin
               r_rd_addr   <= r_rd_addr + ADDR_W'(1);
               r_remaining <= r_remaining - LEN_W'(1);
               r_drain_cnt <= '0;
            end
            DRAIN: begin
               r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
               // Modular subtraction keeps the delta correct across accumulator wrap.
               if (r_drain_cnt == DRAIN_LAST) r_res_data <= mac_out - r_base_snap;
            end
            default: ;
         endcase
      end
   end

endmodule
